// File: rtl/seq_det_pkg.sv
// seq_det_pkg
//   Shared definitions for the serial pattern detection controller:
//   FSM state encoding, state width and default parameter values.
//   Also holds a small helper that decides whether a configured pattern length is legal.

package seq_det_pkg;

  localparam int ST_W      = 2;
  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 8;
  localparam int DEF_TMO_W = 16;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 2'b00,
    ST_READY = 2'b01,
    ST_ARMED = 2'b10
  } state_e;

  // A length is usable when it selects at least one bit and no more than the
  // matcher can hold.
  function automatic logic len_legal(input int unsigned len, input int unsigned max_len);
    return (len != 0) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_match.sv
// seq_det_match
//   Bit-serial pattern matcher.
//   Keeps a shift history and a fill count. It compares the newest len bits
//   against the low len bits of the pattern.
// Ports
//   clk, reset : clock, synchronous active-high reset
//   shift_en   : accept xbit this cycle
//   xbit       : incoming serial bit (becomes hist[0])
//   clear      : drop history and fill (used on arm)
//   len        : active pattern length, 1..PAT_W
//   pattern    : pattern, bit [len-1] is the first bit received
//   overlap    : 1 = keep fill after a hit, 0 = restart fill after a hit
//   hit        : combinational, high when the bit being shifted completes a match

module seq_det_match
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             xbit,
  input  logic             clear,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  input  logic             overlap,
  output logic             hit
);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] hist_new;
  logic [PAT_W-1:0] mask;
  logic [LEN_W-1:0] fill;
  logic [LEN_W-1:0] fill_inc;

  assign hist_new = {hist[PAT_W-2:0], xbit};
  // len == PAT_W shifts every one out, leaving a full mask.
  assign mask     = ~({PAT_W{1'b1}} << len);
  // Saturate at len. The >= also covers a fill left over from a longer, older config.
  assign fill_inc = (fill >= len) ? len : fill + LEN_W'(1);

  assign hit = shift_en && (fill_inc == len) && ((hist_new & mask) == (pattern & mask));

  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift_en) begin
      hist <= hist_new;
      fill <= (hit && !overlap) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl
//   Runtime-configured serial pattern detection controller.
//   Contains the configuration registers, the IDLE/READY/ARMED FSM, the
//   saturating match counter and an optional no-match timeout.
//   Optional feature macro: SEQ_DET_TIMEOUT_EN.
//   When it is not defined, timeout is tied 0 and tmo_limit is ignored.
//
//   state | meaning
//   IDLE  | no valid config stored; arm is ignored
//   READY | config stored; may reconfigure or arm
//   ARMED | bits accepted and matched; config locked
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   cfg_load          : latch cfg_pattern/cfg_len/cfg_overlap (if legal)
//   cfg_pattern/len   : pattern and its length (1..PAT_W)
//   cfg_overlap       : allow overlapping matches
//   arm / disarm      : start / stop detection (disarm wins when both are set)
//   tmo_limit         : non-matching bits before auto-disarm, 0 = off
//   xin_valid, xin    : serial bit stream; xin_ready high only while ARMED
//   match             : one-cycle pulse per detected pattern
//   match_cnt         : matches since last arm, saturating
//   cfg_err           : one-cycle pulse for an illegal or rejected load
//   timeout           : one-cycle pulse on auto-disarm
//   state             : current FSM state

module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int TMO_W = DEF_TMO_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_overlap,
  input  logic             arm,
  input  logic             disarm,
  input  logic [TMO_W-1:0] tmo_limit,
  input  logic             xin_valid,
  input  logic             xin,
  output logic             xin_ready,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err,
  output logic             timeout,
  output logic [ST_W-1:0]  state
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;

  logic cfg_ok;
  logic cfg_we;
  logic cfg_err_d;
  logic arm_go;
  logic accept;
  logic hit;
  logic tmo_fire;

  assign cfg_ok    = len_legal(int'(cfg_len), PAT_W);
  assign accept    = xin_valid && (state_q == ST_ARMED);
  assign xin_ready = (state_q == ST_ARMED);
  assign state     = state_q;

  always_comb begin
    state_d   = state_q;
    cfg_we    = 1'b0;
    cfg_err_d = 1'b0;
    arm_go    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_load) begin
          if (cfg_ok) begin
            cfg_we  = 1'b1;
            state_d = ST_READY;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_READY: begin
        // A load in the same cycle as arm takes priority; the arm is dropped.
        if (cfg_load) begin
          if (cfg_ok) cfg_we = 1'b1;
          else        cfg_err_d = 1'b1;
        end else if (arm && !disarm) begin
          arm_go  = 1'b1;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (cfg_load) cfg_err_d = 1'b1;
        if (disarm || tmo_fire) state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      ovl_q     <= 1'b0;
      match     <= 1'b0;
      match_cnt <= '0;
      cfg_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cfg_we) begin
        pat_q <= cfg_pattern;
        len_q <= cfg_len;
        ovl_q <= cfg_overlap;
      end
      cfg_err <= cfg_err_d;
      match   <= hit;
      timeout <= tmo_fire;
      if (arm_go)
        match_cnt <= '0;
      else if (hit && (match_cnt != {CNT_W{1'b1}}))
        match_cnt <= match_cnt + CNT_W'(1);
    end
  end

  seq_det_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_match (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .xbit     (xin),
    .clear    (arm_go),
    .len      (len_q),
    .pattern  (pat_q),
    .overlap  (ovl_q),
    .hit      (hit)
  );

`ifdef SEQ_DET_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_next;

  assign tmo_next = tmo_cnt + TMO_W'(1);
  // The >= keeps the limit effective if it is lowered below a count already reached.
  assign tmo_fire = accept && !hit && (tmo_limit != '0) && (tmo_next >= tmo_limit);

  always_ff @(posedge clk) begin
    if (reset)
      tmo_cnt <= '0;
    else if (arm_go || (accept && hit))
      tmo_cnt <= '0;
    else if (accept)
      tmo_cnt <= tmo_next;
  end
`else
  logic unused_tmo;
  assign tmo_fire   = 1'b0;
  assign unused_tmo = ^tmo_limit;
`endif

endmodule

// File: tb/tb_seq_det_ctrl.sv
module tb_seq_det_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 2;
  localparam int TMO_W = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             arm;
  logic             disarm;
  logic [TMO_W-1:0] tmo_limit;
  logic             xin_valid;
  logic             xin;
  logic             xin_ready;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cfg_err;
  logic             timeout;
  logic [1:0]       state;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_READY = 2'b01;
  localparam logic [1:0] S_ARMED = 2'b10;

  always #5 clk = ~clk;

  seq_det_ctrl #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W),
    .TMO_W (TMO_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .arm         (arm),
    .disarm      (disarm),
    .tmo_limit   (tmo_limit),
    .xin_valid   (xin_valid),
    .xin         (xin),
    .xin_ready   (xin_ready),
    .match       (match),
    .match_cnt   (match_cnt),
    .cfg_err     (cfg_err),
    .timeout     (timeout),
    .state       (state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] l, input logic o);
    cfg_load = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  task automatic do_disarm();
    disarm = 1'b1;
    tick();
    disarm = 1'b0;
  endtask

  task automatic send(input logic b);
    xin_valid = 1'b1; xin = b;
    tick();
    xin_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    arm = 1'b0; disarm = 1'b0; tmo_limit = '0; xin_valid = 1'b0; xin = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_state", state, S_IDLE);
    chk("rst_match", match, 0);
    chk("rst_cnt", match_cnt, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_ready", xin_ready, 0);

    // illegal loads in IDLE; arm ignored in IDLE
    do_cfg(8'h07, 4'd0, 1'b1);
    chk("len0_err", cfg_err, 1);
    chk("len0_state", state, S_IDLE);
    tick();
    chk("err_clr", cfg_err, 0);
    do_cfg(8'h07, 4'd9, 1'b1);
    chk("len9_err", cfg_err, 1);
    chk("len9_state", state, S_IDLE);
    do_arm();
    chk("idle_arm", state, S_IDLE);

    // 111 overlapping, stream 1x5 -> matches on bits 3,4,5
    do_cfg(8'h07, 4'd3, 1'b1);
    chk("cfg1_state", state, S_READY);
    chk("cfg1_err", cfg_err, 0);
    send(1'b1);
    chk("ready_ignore", match, 0);
    do_arm();
    chk("arm1_state", state, S_ARMED);
    chk("arm1_ready", xin_ready, 1);
    send(1'b1); chk("ov_b1", match, 0);
    send(1'b1); chk("ov_b2", match, 0);
    send(1'b1); chk("ov_b3", match, 1); chk("ov_c3", match_cnt, 1);
    send(1'b1); chk("ov_b4", match, 1); chk("ov_c4", match_cnt, 2);
    send(1'b1); chk("ov_b5", match, 1); chk("ov_c5", match_cnt, 3);
    tick();     chk("ov_idle", match, 0);
    do_disarm();
    chk("dis1_state", state, S_READY);
    chk("dis1_cnt", match_cnt, 3);

    // 111 non-overlapping, stream 1x6 -> matches on bits 3 and 6
    do_cfg(8'h07, 4'd3, 1'b0);
    do_arm();
    chk("arm2_cnt", match_cnt, 0);
    send(1'b1); chk("no_b1", match, 0);
    send(1'b1); chk("no_b2", match, 0);
    send(1'b1); chk("no_b3", match, 1);
    send(1'b1); chk("no_b4", match, 0);
    send(1'b1); chk("no_b5", match, 0);
    send(1'b1); chk("no_b6", match, 1);
    chk("no_cnt", match_cnt, 2);

    // cfg_load while ARMED rejected; stored config (111 non-overlap) kept
    do_cfg(8'h00, 4'd3, 1'b1);
    chk("armed_cfg_err", cfg_err, 1);
    chk("armed_cfg_state", state, S_ARMED);
    send(1'b1); chk("keep_b1", match, 0); chk("keep_err_clr", cfg_err, 0);
    send(1'b1); chk("keep_b2", match, 0);
    send(1'b1); chk("keep_b3", match, 1);
    send(1'b1); chk("keep_b4", match, 0);
    do_disarm();

    // 101 overlapping, stream 1,0,1,0,1 -> matches on bits 3 and 5
    do_cfg(8'h05, 4'd3, 1'b1);
    do_arm();
    send(1'b1); chk("p101_b1", match, 0);
    send(1'b0); chk("p101_b2", match, 0);
    send(1'b1); chk("p101_b3", match, 1);
    send(1'b0); chk("p101_b4", match, 0);
    send(1'b1); chk("p101_b5", match, 1);
    chk("p101_cnt", match_cnt, 2);
    do_disarm();

    // 10 length 2; disarm coincides with the completing 0
    do_cfg(8'h02, 4'd2, 1'b0);
    do_arm();
    send(1'b1); chk("p10_b1", match, 0);
    xin_valid = 1'b1; xin = 1'b0; disarm = 1'b1;
    tick();
    xin_valid = 1'b0; disarm = 1'b0;
    chk("dis_match", match, 1);
    chk("dis_cnt", match_cnt, 1);
    chk("dis_state", state, S_READY);
    chk("dis_ready", xin_ready, 0);
    tick();
    chk("dis_pulse_end", match, 0);
    arm = 1'b1; disarm = 1'b1;
    tick();
    arm = 1'b0; disarm = 1'b0;
    chk("armdis_state", state, S_READY);
    chk("armdis_cnt", match_cnt, 1);

    // cfg_load + arm together in READY: load wins, stays READY
    cfg_load = 1'b1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1'b1; arm = 1'b1;
    tick();
    cfg_load = 1'b0; arm = 1'b0;
    chk("ldarm_state", state, S_READY);

    // pattern 1 length 1: every 1 matches; counter saturates at 3
    do_arm();
    chk("arm5_cnt", match_cnt, 0);
    send(1'b1); chk("sat_b1", match, 1); chk("sat_c1", match_cnt, 1);
    send(1'b1); chk("sat_b2", match, 1); chk("sat_c2", match_cnt, 2);
    send(1'b1); chk("sat_b3", match, 1); chk("sat_c3", match_cnt, 3);
    send(1'b1); chk("sat_b4", match, 1); chk("sat_c4", match_cnt, 3);
    send(1'b1); chk("sat_b5", match, 1); chk("sat_c5", match_cnt, 3);
    send(1'b0); chk("sat_b6", match, 0);
    do_disarm();
    do_arm();
    chk("rearm_cnt", match_cnt, 0);

    // timeout behaviour with tmo_limit=4, pattern 11
    do_disarm();
    do_cfg(8'h03, 4'd2, 1'b1);
    tmo_limit = 16'd4;
    do_arm();
    send(1'b0); chk("tmo_b1", timeout, 0);
    send(1'b0); chk("tmo_b2", timeout, 0);
    send(1'b0); chk("tmo_b3", timeout, 0);
    send(1'b0);
`ifdef SEQ_DET_TIMEOUT_EN
    chk("tmo_b4", timeout, 1);
    chk("tmo_state", state, S_READY);
    tmo_limit = 16'd0;
    do_arm();
    for (int i = 0; i < 6; i++) send(1'b0);
    chk("tmo_off", timeout, 0);
    chk("tmo_off_state", state, S_ARMED);
`else
    chk("tmo_b4", timeout, 0);
    chk("tmo_state", state, S_ARMED);
`endif

    // reset mid-stream: back to IDLE, no match, config lost
    do_disarm();
    do_cfg(8'h07, 4'd3, 1'b1);
    do_arm();
    send(1'b1);
    send(1'b1);
    xin_valid = 1'b1; xin = 1'b1; reset = 1'b1;
    tick();
    xin_valid = 1'b0; reset = 1'b0;
    chk("mid_rst_match", match, 0);
    chk("mid_rst_state", state, S_IDLE);
    chk("mid_rst_cnt", match_cnt, 0);
    do_arm();
    chk("mid_rst_arm", state, S_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
